axis_word_uart_tx: RTL
======================

Name: axis_word_uart_tx

Overview:
Transmit-side counterpart to the UART receive path that packs bytes into 32-bit words. It accepts 32-bit AXI-Stream words with per-byte tkeep and tlast, and serializes the enabled bytes least-significant lane first. Each byte goes out as an 8N1 UART frame on tx_serial_o. It sits between a 32-bit AXIS source (for example a response or loopback path) and the board TX pin, and replaces the separate narrowing adapter plus byte UART.

Parameters:
clks_per_bit_p, 216, clock cycles per UART bit (216 = prescale 27 x 8 at board clock); must be >= 2
data_width_p, 32, AXIS word width; fixed at 32, other values unsupported
keep_width_p, 4, tkeep width = data_width_p/8

Ports:
clk_i  input  1  clock; all logic on rising edge
reset_i  input  1  synchronous, active-high reset
s_axis_tdata_i  input  32  word; lane n = bits [8n+7:8n]
s_axis_tkeep_i  input  4  lane enable; 1 = byte transmitted
s_axis_tvalid_i  input  1  word valid
s_axis_tready_o  output  1  block can accept a word
s_axis_tlast_i  input  1  word ends a frame
tx_serial_o  output  1  UART line, idle high
busy_o  output  1  high while a word is held (any state but IDLE)
frame_done_o  output  1  one-cycle pulse when a tlast word fully completes

Behaviour:
- Reset values: tx_serial_o=1, s_axis_tready_o=1, busy_o=0, frame_done_o=0. The FSM goes to IDLE, counters clear, and the held word is discarded.
- Reset mid-operation: on the cycle after reset_i is sampled high, tx_serial_o is 1. No partial stop bit is completed and no frame_done_o pulse is produced.
- Single-word buffer, no skid. s_axis_tready_o = (state==IDLE).
- Handshake: a word is accepted when tvalid&&tready at a rising edge. On acceptance, tdata, tkeep and tlast are captured into word_r, mask_r and last_r.
- Inputs are ignored while not in IDLE. tdata/tkeep changes while busy have no effect.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE -> START: on acceptance when tkeep!=0. Lane = lowest set bit of mask_r.
- IDLE -> DONE: on acceptance when tkeep==0. No line activity.
- START: tx=0 for exactly clks_per_bit_p cycles, beginning the cycle after acceptance. Then go to DATA.
- DATA: 8 bits, LSB first, each held exactly clks_per_bit_p cycles. A 3-bit bit index counts 0..7, then go to STOP.
- STOP: tx=1 for clks_per_bit_p cycles. At the end of STOP, clear the current lane's bit in mask_r.
  - If the remaining mask is !=0: go to START with the lowest remaining set lane, back-to-back with no idle gap. Disabled lanes cost zero cycles.
  - Otherwise: go to DONE.
- DONE: exactly one cycle; tx=1, tready=0. frame_done_o=1 in this cycle iff last_r. Next state is IDLE.
- Inter-word gap: with tvalid held, two idle-high cycles separate the end of the final stop bit from the next start bit (DONE + IDLE acceptance cycle).
- Baud counter: width $clog2(clks_per_bit_p). It reloads at every bit boundary and counts in every non-IDLE/DONE state. Bit period is exact, with no cumulative drift.
- Lane selection: priority encoder on mask_r, lowest index first. Example: keep=1010 sends lane1 then lane3.
- Wire duration of a word = 10*clks_per_bit_p*popcount(tkeep) cycles + 1 DONE cycle.
- tlast has no effect on serialization; it only gates frame_done_o.
- busy_o=1 from the cycle after acceptance through DONE inclusive.

Test Plan:
- Reset: assert reset_i 3 cycles -> tx_serial_o=1, s_axis_tready_o=1, busy_o=0, frame_done_o=0. Then reset_i low with no traffic -> line stays 1.
- Full word: clks_per_bit_p=8, tdata=0x00B835F2, tkeep=1111, tlast=1.
  - Monitor decodes bytes F2,35,B8,00 in order, each start=0 / stop=1.
  - 320 line cycles total; tready low throughout.
  - frame_done_o pulses exactly once, 1 cycle after the last stop bit.
- Sparse keep: tdata=0xAABBCCDD, tkeep=0101, tlast=0 -> bytes DD then BB only, 160 cycles, no gap between them, no frame_done_o.
- Empty keep: tkeep=0000, tlast=1 -> tx stays 1, frame_done_o pulses on the cycle after acceptance, tready high one cycle later.
- Back-to-back: tvalid held with words 0xC0C0FFEE then 0x11223344, tdata toggled randomly while busy.
  - Decoded bytes: EE,FF,C0,C0,44,33,22,11.
  - Exactly 2 idle-high cycles between the two words.
  - Mid-word tdata changes are ignored.
- Reset mid-byte: assert reset_i during the DATA bit 4 of the first byte.
  - Next cycle: tx=1, tready=1, no frame_done_o.
  - A following word 0x000000A5, keep=0001 transmits A5 correctly.

Source files
------------

// File: rtl/axis_word_uart_tx.sv
// AXI-Stream 32-bit word to 8N1 UART transmitter. Enabled byte lanes are sent
// lowest lane first, back-to-back, with a one-cycle DONE state per word.
module axis_word_uart_tx #(
  parameter int clks_per_bit_p = 216,
  parameter int data_width_p   = 32,
  parameter int keep_width_p   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [data_width_p-1:0] s_axis_tdata_i,
  input  logic [keep_width_p-1:0] s_axis_tkeep_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  input  logic                    s_axis_tlast_i,
  output logic                    tx_serial_o,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam int baud_w_lp = (clks_per_bit_p > 1) ? $clog2(clks_per_bit_p) : 1;
  localparam int lane_w_lp = $clog2(keep_width_p);
  localparam logic [baud_w_lp-1:0] baud_max_lp = baud_w_lp'(clks_per_bit_p - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_e;

  state_e                  state_r;
  logic [data_width_p-1:0] word_r;
  logic [keep_width_p-1:0] mask_r;
  logic [keep_width_p-1:0] mask_next;
  logic                    last_r;
  logic [lane_w_lp-1:0]    lane_r;
  logic [2:0]              bit_idx_r;
  logic [baud_w_lp-1:0]    baud_r;
  logic                    tx_r;
  logic                    frame_done_r;
  logic [7:0]              cur_byte;

  // Priority encoder: lowest enabled lane wins.
  function automatic logic [lane_w_lp-1:0] lowest_lane(input logic [keep_width_p-1:0] m);
    lowest_lane = '0;
    for (int i = keep_width_p - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = lane_w_lp'(i);
    end
  endfunction

  assign cur_byte = word_r[{lane_r, 3'b000} +: 8];

  always_comb begin
    mask_next         = mask_r;
    mask_next[lane_r] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      word_r       <= '0;
      mask_r       <= '0;
      last_r       <= 1'b0;
      lane_r       <= '0;
      bit_idx_r    <= '0;
      baud_r       <= '0;
      tx_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (s_axis_tvalid_i) begin
            word_r    <= s_axis_tdata_i;
            mask_r    <= s_axis_tkeep_i;
            last_r    <= s_axis_tlast_i;
            bit_idx_r <= '0;
            baud_r    <= baud_max_lp;
            if (|s_axis_tkeep_i) begin
              state_r <= START;
              lane_r  <= lowest_lane(s_axis_tkeep_i);
              tx_r    <= 1'b0;
            end else begin
              state_r      <= DONE;
              frame_done_r <= s_axis_tlast_i;
            end
          end
        end
        START: begin
          if (baud_r == '0) begin
            state_r   <= DATA;
            baud_r    <= baud_max_lp;
            bit_idx_r <= '0;
            tx_r      <= cur_byte[0];
          end else begin
            baud_r <= baud_r - baud_w_lp'(1);
          end
        end
        DATA: begin
          if (baud_r == '0) begin
            baud_r <= baud_max_lp;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= cur_byte[bit_idx_r + 3'd1];
            end
          end else begin
            baud_r <= baud_r - baud_w_lp'(1);
          end
        end
        STOP: begin
          // Retire the finished lane and chain straight into the next one.
          if (baud_r == '0) begin
            mask_r <= mask_next;
            baud_r <= baud_max_lp;
            if (|mask_next) begin
              state_r <= START;
              lane_r  <= lowest_lane(mask_next);
              tx_r    <= 1'b0;
            end else begin
              state_r      <= DONE;
              frame_done_r <= last_r;
            end
          end else begin
            baud_r <= baud_r - baud_w_lp'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx_serial_o     = tx_r;
  assign s_axis_tready_o = (state_r == IDLE);
  assign busy_o          = (state_r != IDLE);
  assign frame_done_o    = frame_done_r;

endmodule
